// File: rtl/prog_loader_if.sv
// Stream-in plus memory-write bundle between the boot loader and its neighbours.
// master: image source / memory side; slave: the loader itself.
// Widths follow the loader's DATA_SIZE / ADDR_SIZE parameters.
interface prog_loader_if #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 5
);
  logic                 s_valid;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_ready;
  logic                 mem_w;
  logic                 mem_overwrite;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_w, mem_overwrite, mem_addr, mem_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_w, mem_overwrite, mem_addr, mem_data
  );
endinterface

// File: rtl/prog_loader.sv
// Streams a program image into instruction memory, checksums it, releases the CPU on match.
// Latency: accepted word appears on the memory write port one cycle after its handshake.
// Backpressure: s_ready is high only in LOAD; the source may stall freely (no timeout).
module prog_loader #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE:0]   len,
  input  logic [DATA_SIZE-1:0] exp_sum,
  input  logic                 abort,
  prog_loader_if.slave         bus,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;

  // Largest image that fits between BASE_ADDR and the top of memory.
  localparam logic [ADDR_SIZE:0]   MAX_LEN = (ADDR_SIZE+1)'((1 << ADDR_SIZE) - BASE_ADDR);
  localparam logic [ADDR_SIZE:0]   CNT_ONE = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] BASE    = ADDR_SIZE'(BASE_ADDR);
  localparam logic [ADDR_SIZE-1:0] A_ONE   = ADDR_SIZE'(1);

  localparam logic [1:0] E_LEN   = 2'b01;
  localparam logic [1:0] E_SUM   = 2'b10;
  localparam logic [1:0] E_ABORT = 2'b11;

  state_t               state, state_nxt;
  logic [ADDR_SIZE:0]   count;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] sum;
  logic [DATA_SIZE-1:0] exp_q;
  logic                 done_q;
  logic                 mem_w_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [DATA_SIZE-1:0] mem_data_q;

  logic can_start;
  logic len_ok;
  logic xfer;
  logic last;
  logic sum_ok;

  // abort takes priority over a same-cycle handshake, so the word is dropped.
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign len_ok    = (len != '0) && (len <= MAX_LEN);
  assign xfer      = (state == S_LOAD) && bus.s_valid && !abort;
  assign last      = xfer && (count == CNT_ONE);
  assign sum_ok    = (sum == exp_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = len_ok ? S_LOAD : S_ERROR;
      end
      S_LOAD: begin
        if (abort)     state_nxt = S_ERROR;
        else if (last) state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = sum_ok ? S_DONE : S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; the CPU is only released after a verified image.
  always_comb begin
    bus.s_ready = (state == S_LOAD);
    busy        = (state == S_LOAD) || (state == S_CHECK);
    err         = (state == S_ERROR);
    cpu_hold    = (state != S_DONE);
  end

  // Load bookkeeping: count, address, running checksum and error cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      addr     <= '0;
      sum      <= '0;
      exp_q    <= '0;
      err_code <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == S_CHECK) && sum_ok;
      if (can_start && start) begin
        if (len_ok) begin
          count    <= len;
          exp_q    <= exp_sum;
          addr     <= BASE;
          sum      <= '0;
          err_code <= 2'b00;
        end else begin
          err_code <= E_LEN;
        end
      end else if (state == S_LOAD) begin
        if (abort) begin
          err_code <= E_ABORT;
        end else if (xfer) begin
          // addr may step past the top after the final word; it is never used then.
          sum   <= sum + bus.s_data;
          addr  <= addr + A_ONE;
          count <= count - CNT_ONE;
        end
      end else if ((state == S_CHECK) && !sum_ok) begin
        err_code <= E_SUM;
      end
    end
  end

  // Registered memory write port: one write cycle per accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_w_q <= xfer;
      if (xfer) begin
        mem_addr_q <= addr;
        mem_data_q <= bus.s_data;
      end
    end
  end

  assign bus.mem_w         = mem_w_q;
  assign bus.mem_overwrite = mem_w_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_data      = mem_data_q;
  assign done              = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: image loads, stalls, checksum/len/abort errors, reset.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
// Memory write pulses are tallied on the falling edge.
module tb_prog_loader;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] exp_sum = '0;
  logic          abort = 1'b0;
  logic          cpu_hold, busy, done, err;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr_base;

  prog_loader_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

  prog_loader #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .exp_sum  (exp_sum),
    .abort    (abort),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.mem_w === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [AW:0] l, input logic [DW-1:0] e);
    bus.s_valid = 1'b0;
    start = 1'b1;
    len = l;
    exp_sum = e;
    tick();
    start = 1'b0;
  endtask

  // Present one word after 'gap' idle cycles, then check the write it produces.
  task automatic send(input logic [DW-1:0] d, input int gap, input int a);
    bus.s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      check("stall_no_write", bus.mem_w, 0);
    end
    bus.s_valid = 1'b1;
    bus.s_data = d;
    tick();
    bus.s_valid = 1'b0;
    check("wr_en", bus.mem_w, 1);
    check("wr_ovw", bus.mem_overwrite, 1);
    check("wr_addr", bus.mem_addr, a);
    check("wr_data", bus.mem_data, d);
  endtask

  task automatic send_image(input int gap);
    send(16'h1012, 0, 0);
    send(16'h2023, gap, 1);
    send(16'h3510, gap, 2);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", bus.s_ready, 0);
    check("rst_mem_w", bus.mem_w, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code}, 0);

    // 1: back-to-back image, checksum 0x1012+0x2023+0x3510 = 0x6545
    wr_base = wr_cnt;
    do_start(6'd3, 16'h6545);
    check("t1_ready", bus.s_ready, 1);
    check("t1_busy", busy, 1);
    check("t1_hold", cpu_hold, 1);
    send_image(0);
    check("t1_check_ready", bus.s_ready, 0);
    check("t1_check_busy", busy, 1);
    tick();
    check("t1_done", done, 1);
    check("t1_hold_rel", cpu_hold, 0);
    check("t1_no_wr", bus.mem_w, 0);
    check("t1_busy_off", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_hold_stays", cpu_hold, 0);
    check("t1_wr_count", wr_cnt - wr_base, 3);

    // 2: same image with 2 stall cycles between words
    wr_base = wr_cnt;
    do_start(6'd3, 16'h6545);
    check("t2_hold", cpu_hold, 1);
    send_image(2);
    tick();
    check("t2_done", done, 1);
    check("t2_hold_rel", cpu_hold, 0);
    check("t2_wr_count", wr_cnt - wr_base, 3);

    // 3: checksum mismatch
    do_start(6'd3, 16'h6546);
    send_image(0);
    tick();
    check("t3_err", err, 1);
    check("t3_code", err_code, 2'b10);
    check("t3_hold", cpu_hold, 1);
    check("t3_done", done, 0);
    tick();
    check("t3_err_holds", {err, err_code}, 3'b110);

    // 4: bad lengths, then a full 32-word image (sum 1..32 = 0x210)
    wr_base = wr_cnt;
    do_start(6'd0, 16'h0000);
    check("t4_len0_err", {err, err_code}, 3'b101);
    check("t4_len0_busy", busy, 0);
    do_start(6'd33, 16'h0000);
    check("t4_len33_err", {err, err_code}, 3'b101);
    tick();
    check("t4_no_wr", wr_cnt - wr_base, 0);
    do_start(6'd32, 16'h0210);
    check("t4_err_clr", {err, err_code}, 3'b000);
    check("t4_busy", busy, 1);
    for (int i = 0; i < 32; i++) send(16'(i + 1), 0, i);
    check("t4_last_addr", bus.mem_addr, 31);
    tick();
    check("t4_done", done, 1);
    check("t4_wr_count", wr_cnt - wr_base, 32);

    // 5: abort with the second handshake, then a clean restart
    wr_base = wr_cnt;
    do_start(6'd3, 16'h6545);
    send(16'h1012, 0, 0);
    bus.s_valid = 1'b1;
    bus.s_data = 16'h2023;
    abort = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    abort = 1'b0;
    check("t5_err", {err, err_code}, 3'b111);
    check("t5_no_wr", bus.mem_w, 0);
    check("t5_hold", cpu_hold, 1);
    tick();
    check("t5_wr_count", wr_cnt - wr_base, 1);
    do_start(6'd3, 16'h6545);
    check("t5_restart_clr", {err, err_code}, 3'b000);
    send_image(0);
    tick();
    check("t5_done", done, 1);
    check("t5_hold_rel", cpu_hold, 0);

    // 6: reset during LOAD with a word on offer
    do_start(6'd3, 16'h6545);
    send(16'h1012, 0, 0);
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 16'h2023;
    tick();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    check("t6_hold", cpu_hold, 1);
    check("t6_ready", bus.s_ready, 0);
    check("t6_mem_w", bus.mem_w, 0);
    check("t6_busy", busy, 0);
    check("t6_addr", bus.mem_addr, 0);
    check("t6_err", {err, err_code}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
